// File: rtl/router_pkt_source.sv
// Router packet transmitter: stages up to 63 bytes, then sends header, payload and parity.
// Header visible the cycle after start; each beat holds while busy, and a long stall aborts the packet.
module router_pkt_source #(
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic       inject_err,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_idle,
  output logic [5:0] buf_count,
  output logic       buf_full,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] dest;
  } hdr_t;

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state;
  logic [7:0] buf_mem [0:62];
  logic [5:0] pkt_len;
  logic       inj;
  logic [5:0] idx;
  logic [7:0] par;
  logic [7:0] tmo_cnt;

  hdr_t start_hdr;
  logic in_beat;
  logic start_acc;
  logic wr_acc;
  logic tmo_hit;

  assign start_hdr = '{len: buf_count, dest: dest};
  assign in_beat   = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY);
  assign start_acc = (state == S_IDLE) && start && (buf_count != 6'd0);
  assign wr_acc    = (state == S_IDLE) && wr_en && !buf_full && !start_acc;
  // The stalled cycle that would bring the count to BUSY_TIMEOUT is the abort edge.
  assign tmo_hit   = in_beat && busy && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (wr_acc) buf_mem[buf_count] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pkt_valid <= 1'b0;
      data_out  <= 8'h00;
      tx_idle   <= 1'b1;
      buf_count <= 6'd0;
      buf_full  <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      pkt_len   <= 6'd0;
      inj       <= 1'b0;
      idx       <= 6'd0;
      par       <= 8'h00;
      tmo_cnt   <= 8'h00;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            state     <= S_HEADER;
            pkt_len   <= buf_count;
            inj       <= inject_err;
            pkt_valid <= 1'b1;
            data_out  <= start_hdr;
            tx_idle   <= 1'b0;
            idx       <= 6'd0;
            par       <= 8'h00;
            tmo_cnt   <= 8'h00;
          end else if (wr_acc) begin
            buf_count <= buf_count + 6'd1;
            buf_full  <= (buf_count == 6'd62);
          end
        end
        S_GAP: begin
          state   <= S_IDLE;
          tx_idle <= 1'b1;
        end
        default: begin
          if (tmo_hit) begin
            state     <= S_IDLE;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            tx_idle   <= 1'b1;
            timeout   <= 1'b1;
            buf_count <= 6'd0;
            buf_full  <= 1'b0;
            tmo_cnt   <= 8'h00;
          end else if (busy) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end else begin
            tmo_cnt <= 8'h00;
            case (state)
              S_HEADER: begin
                state    <= S_PAYLOAD;
                par      <= data_out;
                data_out <= buf_mem[0];
              end
              S_PAYLOAD: begin
                par <= par ^ data_out;
                if (idx == pkt_len - 6'd1) begin
                  state     <= S_PARITY;
                  pkt_valid <= 1'b0;
                  data_out  <= par ^ data_out ^ {8{inj}};
                end else begin
                  idx      <= idx + 6'd1;
                  data_out <= buf_mem[idx + 6'd1];
                end
              end
              S_PARITY: begin
                state     <= S_GAP;
                data_out  <= 8'h00;
                done      <= 1'b1;
                buf_count <= 6'd0;
                buf_full  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_source.sv
// Directed bench for router_pkt_source with a short busy timeout.
module tb_router_pkt_source;

  logic       clock = 1'b0;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest;
  logic       inject_err;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_idle;
  logic [5:0] buf_count;
  logic       buf_full;
  logic       done;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  router_pkt_source #(.BUSY_TIMEOUT(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .dest       (dest),
    .inject_err (inject_err),
    .busy       (busy),
    .pkt_valid  (pkt_valid),
    .data_out   (data_out),
    .tx_idle    (tx_idle),
    .buf_count  (buf_count),
    .buf_full   (buf_full),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] d, input logic ie);
    start      = 1'b1;
    dest       = d;
    inject_err = ie;
    step();
    start      = 1'b0;
    inject_err = 1'b0;
  endtask

  // Observed {pkt_valid,data_out,tx_idle,buf_count,buf_full,done,timeout}
  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++;
    if ({pkt_valid, data_out, tx_idle, buf_count, buf_full, done, timeout} !== {1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", {pkt_valid, data_out, tx_idle, buf_count, buf_full, done, timeout},
               {1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single(input logic ie, input logic [7:0] exp_par);
    write_byte(8'hA5);
    checks++;
    if (buf_count !== 6'd1) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", buf_count);
    end
    do_start(2'd1, ie);
    checks++;
    if ({pkt_valid, data_out, tx_idle} !== {1'b1, 8'h05, 1'b0}) begin
      failures++;
      $display("FAIL single_hdr got=%b/%h/%b want=1/05/0", pkt_valid, data_out, tx_idle);
    end
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL single_pay got=%b/%h want=1/a5", pkt_valid, data_out);
    end
    step();
    checks++;
    if ({pkt_valid, data_out, done} !== {1'b0, exp_par, 1'b0}) begin
      failures++;
      $display("FAIL single_par got=%b/%h/%b want=0/%h/0", pkt_valid, data_out, done, exp_par);
    end
    step();
    checks++;
    if ({done, tx_idle, buf_count, pkt_valid, data_out} !== {1'b1, 1'b0, 6'd0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL single_gap got=%b/%b/%0d/%b/%h want=1/0/0/0/00", done, tx_idle, buf_count, pkt_valid, data_out);
    end
    step();
    checks++;
    if ({done, tx_idle} !== 2'b01) begin
      failures++;
      $display("FAIL single_idle got=%b/%b want=0/1", done, tx_idle);
    end
  endtask

  task automatic test_stall();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    // wr_en alongside start must be dropped
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    do_start(2'd2, 1'b0);
    wr_en   = 1'b0;
    checks++;
    if ({pkt_valid, data_out, buf_count} !== {1'b1, 8'h0E, 6'd3}) begin
      failures++;
      $display("FAIL stall_hdr got=%b/%h/%0d want=1/0e/3", pkt_valid, data_out, buf_count);
    end
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pkt_valid, data_out, timeout} !== {1'b1, 8'h0E, 1'b0}) begin
        failures++;
        $display("FAIL stall_hdr_hold[%0d] got=%b/%h/%b want=1/0e/0", i, pkt_valid, data_out, timeout);
      end
    end
    busy = 1'b0;
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'h11}) begin
      failures++;
      $display("FAIL stall_b0 got=%b/%h want=1/11", pkt_valid, data_out);
    end
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'h22}) begin
      failures++;
      $display("FAIL stall_b1 got=%b/%h want=1/22", pkt_valid, data_out);
    end
    busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({pkt_valid, data_out} !== {1'b1, 8'h22}) begin
        failures++;
        $display("FAIL stall_b1_hold[%0d] got=%b/%h want=1/22", i, pkt_valid, data_out);
      end
    end
    busy = 1'b0;
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'h33}) begin
      failures++;
      $display("FAIL stall_b2 got=%b/%h want=1/33", pkt_valid, data_out);
    end
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b0, 8'h0E}) begin
      failures++;
      $display("FAIL stall_par got=%b/%h want=0/0e", pkt_valid, data_out);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done got=%b want=1", done);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) begin
      write_byte(8'(i));
      if (i == 61) begin
        checks++;
        if ({buf_count, buf_full} !== {6'd62, 1'b0}) begin
          failures++;
          $display("FAIL full_62 got=%0d/%b want=62/0", buf_count, buf_full);
        end
      end
    end
    checks++;
    if ({buf_count, buf_full} !== {6'd63, 1'b1}) begin
      failures++;
      $display("FAIL full_63 got=%0d/%b want=63/1", buf_count, buf_full);
    end
    do_start(2'd0, 1'b0);
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'hFC}) begin
      failures++;
      $display("FAIL full_hdr got=%b/%h want=1/fc", pkt_valid, data_out);
    end
    for (int i = 0; i < 63; i++) begin
      step();
      checks++;
      if ({pkt_valid, data_out} !== {1'b1, 8'(i)}) begin
        failures++;
        $display("FAIL full_pay[%0d] got=%b/%h want=1/%h", i, pkt_valid, data_out, 8'(i));
      end
    end
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b0, 8'hC3}) begin
      failures++;
      $display("FAIL full_par got=%b/%h want=0/c3", pkt_valid, data_out);
    end
    step();
    checks++;
    if ({done, buf_count, buf_full} !== {1'b1, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL full_done got=%b/%0d/%b want=1/0/0", done, buf_count, buf_full);
    end
    step();
  endtask

  task automatic test_timeout();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    do_start(2'd0, 1'b0);
    step();
    step();
    busy = 1'b1;
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'h02}) begin
      failures++;
      $display("FAIL tmo_b1 got=%b/%h want=1/02", pkt_valid, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pkt_valid, data_out, timeout} !== {1'b1, 8'h02, 1'b0}) begin
        failures++;
        $display("FAIL tmo_hold[%0d] got=%b/%h/%b want=1/02/0", i, pkt_valid, data_out, timeout);
      end
    end
    step();
    checks++;
    if ({timeout, pkt_valid, data_out, tx_idle, buf_count} !== {1'b1, 1'b0, 8'h00, 1'b1, 6'd0}) begin
      failures++;
      $display("FAIL tmo_abort got=%b/%b/%h/%b/%0d want=1/0/00/1/0", timeout, pkt_valid, data_out, tx_idle, buf_count);
    end
    busy = 1'b0;
    step();
    checks++;
    if ({timeout, tx_idle, pkt_valid} !== 3'b010) begin
      failures++;
      $display("FAIL tmo_pulse got=%b/%b/%b want=0/1/0", timeout, tx_idle, pkt_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    do_start(2'd1, 1'b0);
    step();
    step();
    checks++;
    if ({pkt_valid, data_out} !== {1'b1, 8'h41}) begin
      failures++;
      $display("FAIL rst_mid_b1 got=%b/%h want=1/41", pkt_valid, data_out);
    end
    resetn = 1'b0;
    step();
    checks++;
    if ({pkt_valid, data_out, tx_idle, buf_count, buf_full, done, timeout} !== {1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_values got=%h want=%h", {pkt_valid, data_out, tx_idle, buf_count, buf_full, done, timeout},
               {1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0});
    end
    resetn = 1'b1;
    step();
    do_start(2'd2, 1'b0);
    checks++;
    if ({tx_idle, pkt_valid, data_out} !== {1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL empty_start got=%b/%b/%h want=1/0/00", tx_idle, pkt_valid, data_out);
    end
    step();
    checks++;
    if ({tx_idle, pkt_valid} !== 2'b10) begin
      failures++;
      $display("FAIL empty_start_hold got=%b/%b want=1/0", tx_idle, pkt_valid);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    start      = 1'b0;
    dest       = 2'd0;
    inject_err = 1'b0;
    busy       = 1'b0;
    test_reset();
    test_single(1'b0, 8'hA0);
    test_stall();
    test_full();
    test_timeout();
    test_single(1'b1, 8'h5F);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
